// File: rtl/vic_sound_pkg.sv
// Shared constants and types for the VIC-20 6560-style sound stage:
// register offsets, prescaler strobe masks, voice register layout and the noise LFSR step.
package vic_sound_pkg;

  localparam logic [3:0] REG_BASS  = 4'hA;
  localparam logic [3:0] REG_ALTO  = 4'hB;
  localparam logic [3:0] REG_SOP   = 4'hC;
  localparam logic [3:0] REG_NOISE = 4'hD;
  localparam logic [3:0] REG_VOL   = 4'hE;

  // A voice strobes on the clken where all masked prescaler bits are zero.
  localparam logic [7:0] STROBE_BASS  = 8'hFF;
  localparam logic [7:0] STROBE_ALTO  = 8'h7F;
  localparam logic [7:0] STROBE_SOP   = 8'h3F;
  localparam logic [7:0] STROBE_NOISE = 8'h1F;
  localparam logic [3:0][7:0] STROBE_MASK = {STROBE_NOISE, STROBE_SOP, STROBE_ALTO, STROBE_BASS};

  // Feedback taps l[15], l[13], l[12], l[10].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic       en;
    logic [6:0] freq;
  } voice_reg_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vic_sound_if.sv
// CPU-side register port of the sound stage: select, write strobe, offset, data in/out.
interface vic_sound_if;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, we, addr, din, input dout);
  modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/vic_sound_voice.sv
// One tone generator: 7-bit up-counter reloaded from freq, toggling a square bit at each reload.
module vic_sound_voice
  import vic_sound_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken_i,
  input  logic       strobe_i,
  input  voice_reg_t cfg_i,
  output logic       sq_o,
  output logic       reload_o
);

  logic [6:0] cnt_q, cnt_d;
  logic       sq_q, sq_d;

  assign reload_o = clken_i & strobe_i & cfg_i.en & (cnt_q == 7'h7F);
  assign sq_o     = sq_q;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clken_i) begin
      if (!cfg_i.en) begin
        cnt_d = cfg_i.freq;
        sq_d  = 1'b0;
      end else if (strobe_i) begin
        if (cnt_q == 7'h7F) begin
          cnt_d = cfg_i.freq;
          sq_d  = ~sq_q;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

endmodule

// File: rtl/vic_sound.sv
// VIC-20 6560-style audio: register file $900A-$900E, shared prescaler, three square voices,
// one LFSR noise voice and a registered 4-bit volume mix.
module vic_sound
  import vic_sound_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'h0001,
  parameter bit          SAT_MIX   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken,
  vic_sound_if.slave bus,
  output logic [3:0] audio,
  output logic [3:0] voice_on
);

  voice_reg_t [3:0] vreg_q, vreg_d;
  logic [7:0]       vol_q, vol_d;
  logic [7:0]       pre_q, pre_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       audio_q, audio_d;
  logic [3:0]       sq, reload;
  logic             wr_en;
  logic             unused_voice;

  // Voice count times volume, quartered; the saturation path leaves headroom for future weighting.
  function automatic logic [3:0] mix(input logic [3:0] von, input logic [3:0] vol);
    logic [2:0] n;
    logic [5:0] prod;
    n    = 3'($countones(von));
    prod = {3'b000, n} * {2'b00, vol};
    if (SAT_MIX && (prod > 6'd60)) return 4'hF;
    return prod[5:2];
  endfunction

  assign wr_en = bus.cs & bus.we & clken;

  always_comb begin
    vreg_d = vreg_q;
    vol_d  = vol_q;
    if (wr_en) begin
      case (bus.addr)
        REG_BASS:  vreg_d[0] = voice_reg_t'(bus.din);
        REG_ALTO:  vreg_d[1] = voice_reg_t'(bus.din);
        REG_SOP:   vreg_d[2] = voice_reg_t'(bus.din);
        REG_NOISE: vreg_d[3] = voice_reg_t'(bus.din);
        REG_VOL:   vol_d     = bus.din;
        default:   ;
      endcase
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    case (bus.addr)
      REG_BASS:  bus.dout = vreg_q[0];
      REG_ALTO:  bus.dout = vreg_q[1];
      REG_SOP:   bus.dout = vreg_q[2];
      REG_NOISE: bus.dout = vreg_q[3];
      REG_VOL:   bus.dout = vol_q;
      default:   ;
    endcase
  end

  // Voices see the pre-write register values, so a write on a strobe clken acts one clken later.
  for (genvar g = 0; g < 4; g++) begin : g_voice
    vic_sound_voice u_voice (
      .clk      (clk),
      .reset_n  (reset_n),
      .clken_i  (clken),
      .strobe_i ((pre_q & STROBE_MASK[g]) == 8'h00),
      .cfg_i    (vreg_q[g]),
      .sq_o     (sq[g]),
      .reload_o (reload[g])
    );
  end

  assign unused_voice = ^{sq[3], reload[2:0]};

  assign pre_d    = clken ? pre_q + 8'd1 : pre_q;
  assign lfsr_d   = reload[3] ? lfsr_next(lfsr_q) : lfsr_q;
  assign voice_on = {lfsr_q[0] & vreg_q[3].en, sq[2:0]};
  assign audio_d  = mix(voice_on, vol_q[3:0]);
  assign audio    = audio_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vreg_q  <= '0;
      vol_q   <= '0;
      pre_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      audio_q <= '0;
    end else begin
      vreg_q  <= vreg_d;
      vol_q   <= vol_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      audio_q <= audio_d;
    end
  end

endmodule

// File: tb/tb_vic_sound.sv
// Self-checking bench for vic_sound: a cycle model of registers, prescaler, voices and LFSR
// feeds an audio scoreboard queue, plus table-driven register vectors and timing sequences.
module tb_vic_sound;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       clken   = 1'b1;
  logic [3:0] audio;
  logic [3:0] voice_on;

  vic_sound_if bus();

  vic_sound #(.LFSR_SEED(16'h0001), .SAT_MIX(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .bus      (bus),
    .audio    (audio),
    .voice_on (voice_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int prints = 0;
  int cyc    = 0;
  int rel    = 0;

  // Reference model state
  logic [7:0]  m_reg [5];
  logic [7:0]  m_pre;
  logic [6:0]  m_cnt [4];
  logic        m_sq  [4];
  logic [15:0] m_lfsr;
  localparam logic [7:0] MASKS [4] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F};

  int         aud_q[$];
  logic [7:0] rd_q[$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [3:0] m_von();
    return {m_lfsr[0] & m_reg[3][7], m_sq[2], m_sq[1], m_sq[0]};
  endfunction

  function automatic int ref_mix(input logic [3:0] v, input logic [3:0] vol);
    return ($countones(v) * int'(vol)) / 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 7'h00;
      m_sq[i]  = 1'b0;
    end
    m_pre  = 8'h00;
    m_lfsr = 16'h0001;
    aud_q.delete();
  endtask

  task automatic model_step();
    if (clken) begin
      for (int v = 0; v < 4; v++) begin
        if (!m_reg[v][7]) begin
          m_cnt[v] = m_reg[v][6:0];
          m_sq[v]  = 1'b0;
        end else if ((m_pre & MASKS[v]) == 8'h00) begin
          if (m_cnt[v] == 7'h7F) begin
            m_cnt[v] = m_reg[v][6:0];
            m_sq[v]  = ~m_sq[v];
            if (v == 3) m_lfsr = lfsr_step(m_lfsr);
          end else begin
            m_cnt[v] = m_cnt[v] + 7'd1;
          end
        end
      end
      m_pre = m_pre + 8'd1;
      if (bus.cs && bus.we && (bus.addr >= 4'hA) && (bus.addr <= 4'hE))
        m_reg[int'(bus.addr) - 10] = bus.din;
    end
  endtask

  // One clock: queue the audio the DUT owes for this edge, advance the model, compare after the edge.
  task automatic tick();
    int e;
    e = reset_n ? ref_mix(m_von(), m_reg[4][3:0]) : 0;
    aud_q.push_back(e);
    @(posedge clk);
    if (reset_n) model_step();
    cyc++;
    #1;
    check("audio", audio, aud_q.pop_front());
    check("voice_on", voice_on, m_von());
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.cs   = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    tick();
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clken   = 1'b1;
    bus.cs  = 1'b0;
    bus.we  = 1'b0;
    model_reset();
    repeat (3) tick();
    for (int a = 10; a <= 14; a++) begin
      bus.addr = 4'(a);
      #1;
      check("reset_dout", bus.dout, 0);
    end
    reset_n = 1'b1;
    rel     = cyc;
  endtask

  task automatic wait_toggle(input int idx, input int budget, output int at);
    logic start;
    int   n;
    start = voice_on[idx];
    n     = 0;
    while ((voice_on[idx] == start) && (n < budget)) begin
      tick();
      n++;
    end
    check("toggle_seen", int'(voice_on[idx] != start), 1);
    at = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t [6];
    int tt, w, lf_r;
    logic [15:0] lf;
    logic saw15, nz;

    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.din = 8'h00;

    // Reset state and register file
    do_reset();
    tbl[0] = '{4'hA, 8'h12, 8'h12};
    tbl[1] = '{4'hB, 8'h85, 8'h85};
    tbl[2] = '{4'hC, 8'h7E, 8'h7E};
    tbl[3] = '{4'hD, 8'h3C, 8'h3C};
    tbl[4] = '{4'hE, 8'hA5, 8'hA5};
    tbl[5] = '{4'h0, 8'hFF, 8'h00};
    tbl[6] = '{4'h9, 8'h77, 8'h00};
    tbl[7] = '{4'hF, 8'h55, 8'h00};
    tbl[8] = '{4'hA, 8'hFF, 8'hFF};
    tbl[9] = '{4'hE, 8'h0F, 8'h0F};
    for (int i = 0; i < 10; i++) begin
      write(tbl[i].addr, tbl[i].din);
      rd_q.push_back(tbl[i].exp);
      bus.addr = tbl[i].addr;
      #1;
      check("readback", bus.dout, rd_q.pop_front());
    end
    repeat (300) tick();

    // Soprano square at freq 126, volume 15
    do_reset();
    write(4'hC, 8'h7E);
    write(4'hC, 8'hFE);
    write(4'hE, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      wait_toggle(2, 300, t[k]);
      tick();
      check("sop_audio", audio, (k % 2 == 0) ? 3 : 0);
    end
    check("sop_first_toggle", t[0] - rel - 1, 128);
    for (int k = 1; k < 4; k++) check("sop_half_period", t[k] - t[k-1], 128);

    // Mid-period frequency change only applies from the next reload
    repeat (10) tick();
    write(4'hC, 8'hF0);
    wait_toggle(2, 300, t[4]);
    check("freq_change_old", t[4] - t[3], 128);
    wait_toggle(2, 1100, t[5]);
    check("freq_change_new", t[5] - t[4], 1024);

    // Disable while high clears the square bit on the following clken
    wait_toggle(2, 1100, tt);
    write(4'hC, 8'h00);
    tick();
    check("disable_sq", voice_on[2], 0);

    // Re-enable: first toggle after 16 soprano strobes
    write(4'hC, 8'h70);
    write(4'hC, 8'hF0);
    w = cyc;
    wait_toggle(2, 1200, tt);
    check("reenable_window", int'((tt - w >= 961) && (tt - w <= 1024)), 1);
    tick();
    check("tone_audio", audio, 3);

    // Asynchronous reset mid-tone
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_async_audio", audio, 0);
    check("reset_async_von", voice_on, 0);
    do_reset();
    repeat (20) tick();

    // Bass at freq 0: longest half period
    do_reset();
    write(4'hA, 8'h80);
    wait_toggle(0, 33000, tt);
    check("bass_half_period", tt - rel - 1, 32768);
    check("alto_sop_quiet", voice_on[2:1], 0);

    // All voices at freq 127, full volume, then volume 0
    do_reset();
    for (int a = 10; a <= 13; a++) write(4'(a), 8'h7F);
    for (int a = 10; a <= 13; a++) write(4'(a), 8'hFF);
    write(4'hE, 8'h0F);
    saw15 = 1'b0;
    repeat (8192) begin
      tick();
      if (audio == 4'hF) saw15 = 1'b1;
    end
    check("all_voices_full", saw15, 1);
    write(4'hE, 8'h00);
    tick();
    nz = 1'b0;
    repeat (1000) begin
      tick();
      if (audio != 4'h0) nz = 1'b1;
    end
    check("vol0_silent", nz, 0);

    // Noise LFSR over 64 reloads from seed 1
    do_reset();
    write(4'hD, 8'h7F);
    write(4'hD, 8'hFF);
    lf = 16'h0001;
    for (int r = 1; r <= 64; r++) begin
      lf   = lfsr_step(lf);
      lf_r = 32 * r;
      while (cyc - rel - 1 < lf_r) tick();
      check("noise_bit", voice_on[3], lf[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
